// File: rtl/zeroriscy_dmem_pkg.sv
// zeroriscy_dmem_pkg: shared types and owner encodings for the data-memory arbiter
package zeroriscy_dmem_pkg;
  localparam int PKG_ADDR_W = 32;
  localparam int PKG_DATA_W = 32;
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;
  typedef enum logic {ARB, LOCK} arb_state_e;
  typedef struct packed {
    logic                    we;
    logic [PKG_DATA_W/8-1:0] be;
    logic [PKG_ADDR_W-1:0]   addr;
    logic [PKG_DATA_W-1:0]   wdata;
  } mem_req_t;
endpackage

// File: rtl/zeroriscy_dmem_rr.sv
// zeroriscy_dmem_rr: two-input round-robin picker with master-0 mask and forced favour-m0
module zeroriscy_dmem_rr
  import zeroriscy_dmem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       mask,
  input  logic       favour_m0,
  output logic [1:0] gnt
);
  logic       prio;
  logic [1:0] eff;
  always_comb begin
    eff    = reset ? 2'b00 : {req[1], req[0] & ~mask};
    gnt[0] = eff[0] & (~eff[1] | (prio == M0));
    gnt[1] = eff[1] & (~eff[0] | (prio == M1));
  end
  always_ff @(posedge clk) begin
    if (reset) prio <= M0;
    else if (favour_m0) prio <= M0;
    else if (|gnt) prio <= gnt[0] ? M1 : M0;
  end
endmodule

// File: rtl/zeroriscy_dmem_arb.sv
// zeroriscy_dmem_arb: two-master req/gnt/rvalid arbiter onto a single-port data SRAM
module zeroriscy_dmem_arb
  import zeroriscy_dmem_pkg::*;
#(
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req_i,
  input  logic [31:0]         m0_addr_i,
  input  logic                m0_we_i,
  input  logic [DATA_W/8-1:0] m0_be_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  output logic                m0_gnt_o,
  output logic                m0_rvalid_o,
  output logic [DATA_W-1:0]   m0_rdata_o,
  input  logic                m1_req_i,
  input  logic [31:0]         m1_addr_i,
  input  logic                m1_we_i,
  input  logic [DATA_W/8-1:0] m1_be_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  input  logic                m1_lock_i,
  output logic                m1_gnt_o,
  output logic                m1_rvalid_o,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                mem_en_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-3:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic [DATA_W-1:0]   mem_rdata_i
);
  localparam int CW = $clog2(LOCK_MAX);
  arb_state_e        state;
  logic [CW-1:0]     cnt;
  logic              pend, owner, lock_last, unused_addr;
  logic [1:0]        gnt;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  mem_req_t          sel;
  zeroriscy_dmem_rr u_rr (
    .clk       (clk),
    .reset     (reset),
    .req       ({m1_req_i, m0_req_i}),
    .mask      (state == LOCK),
    .favour_m0 (lock_last),
    .gnt       (gnt)
  );
  assign lock_last = (state == LOCK) && gnt[1] && (cnt == CW'(LOCK_MAX - 1));
  assign m0_gnt_o = gnt[0];
  assign m1_gnt_o = gnt[1];
  assign mem_en_o = |gnt;
  always_comb begin
    sel = gnt[1] ? mem_req_t'{m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i}
                 : mem_req_t'{m0_we_i, m0_be_i, m0_addr_i, m0_wdata_i};
    mem_we_o    = sel.we;
    mem_be_o    = sel.be;
    mem_addr_o  = sel.addr[ADDR_W-1:2];
    mem_wdata_o = sel.wdata;
    unused_addr = ^{sel.addr[PKG_ADDR_W-1:ADDR_W], sel.addr[1:0]};
  end
  assign m0_rvalid_o = ~reset & pend & (owner == M0);
  assign m1_rvalid_o = ~reset & pend & (owner == M1);
  assign m0_rdata_o  = reset ? '0 : m0_rvalid_o ? mem_rdata_i : rdata0_q;
  assign m1_rdata_o  = reset ? '0 : m1_rvalid_o ? mem_rdata_i : rdata1_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARB;
      cnt      <= '0;
      pend     <= 1'b0;
      owner    <= M0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      pend <= |gnt;
      if (|gnt) owner <= gnt[1] ? M1 : M0;
      if (m0_rvalid_o) rdata0_q <= mem_rdata_i;
      if (m1_rvalid_o) rdata1_q <= mem_rdata_i;
      if (state == ARB) begin
        if (gnt[1] && m1_lock_i) begin
          state <= LOCK;
          cnt   <= '0;
        end
      end else begin
        if (gnt[1]) cnt <= cnt + 1'b1;
        if (!m1_lock_i || lock_last) state <= ARB;
      end
    end
  end
endmodule

// File: doc/zeroriscy_dmem_arb.md
Name: zeroriscy_dmem_arb

Overview:
Two-master arbiter that shares the single-port data SRAM. Master 0 is the zero-riscy LSU data port. Master 1 is the host/loader port, used for program load, tohost polling and debug peeks. It sits between zeroriscy_core and zeroriscy_dp_sram in zeroriscy_sim_top. It implements the core's req/gnt/rvalid protocol on both masters, with round-robin arbitration and an optional master-1 lock for burst loading.

Parameters:
ADDR_W, 18, byte-address bits decoded into the SRAM; word address = addr[ADDR_W-1:2]
DATA_W, 32, data width; byte-enable width = DATA_W/8
LOCK_MAX, 256, maximum consecutive master-1 grants while locked before a forced release

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
m0_req_i  in  1  core data request
m0_addr_i  in  32  core byte address
m0_we_i  in  1  core write enable
m0_be_i  in  DATA_W/8  core byte enables
m0_wdata_i  in  DATA_W  core write data
m0_gnt_o  out  1  core grant
m0_rvalid_o  out  1  core response valid
m0_rdata_o  out  DATA_W  core read data
m1_req_i, m1_addr_i, m1_we_i, m1_be_i, m1_wdata_i  in  same widths as m0  host request
m1_lock_i  in  1  host requests exclusive ownership
m1_gnt_o, m1_rvalid_o, m1_rdata_o  out  same widths as m0  host grant/response
mem_en_o  out  1  SRAM access strobe
mem_we_o  out  1  SRAM write
mem_be_o  out  DATA_W/8  SRAM byte enables
mem_addr_o  out  ADDR_W-2  SRAM word address
mem_wdata_o  out  DATA_W  SRAM write data
mem_rdata_i  in  DATA_W  SRAM read data, valid one cycle after mem_en_o

Behaviour:
- Reset: all gnt/rvalid outputs 0, mem_en_o 0, rdata outputs 0. RR pointer = master 0. State = ARB. Lock counter = 0. Any in-flight response is discarded.
- Grant is combinational in the request cycle. Exactly one of m0_gnt_o/m1_gnt_o may be high. mem_en_o = m0_gnt_o | m1_gnt_o.
- Mem-side muxing: mem_* fields come from the granted master. mem_addr_o = addr[ADDR_W-1:2]; upper address bits are ignored.
- Response: rvalid is asserted exactly 1 cycle after the grant, for both reads and writes, on the granting master only.
- rdata: rdata = mem_rdata_i when rvalid is high. Otherwise rdata holds its last value.
- Owner register: a 1-bit owner register plus a pending flag route the response.
- Masters are not required to hold req after gnt. Outstanding depth is 1 per cycle, fully pipelined: back-to-back grants are legal.
- State ARB:
  - Single requester: that requester is granted.
  - Both requesting: the master not granted last wins (RR). The pointer updates only on a grant.
  - A grant to m1 with m1_lock_i=1 moves the state to LOCK and clears the lock counter.
- State LOCK:
  - m0 is never granted; m0_gnt_o = 0.
  - m1 is granted whenever it requests. Each grant increments the lock counter.
  - Return to ARB when m1_lock_i=0, or when the counter reaches LOCK_MAX-1 on a grant. On a forced release the RR pointer is set to favour m0.
  - The exit takes effect the next cycle. m1's last locked access completes normally.
- Simultaneous events:
  - m1_lock_i rising while m0 wins RR: m0 is granted first; LOCK is entered on m1's next grant.
  - A lock release and a new m1 lock in the same cycle: one ARB cycle is still taken before re-locking.
- Reset mid-transaction: a pending rvalid is dropped (no rvalid after reset). The SRAM access already issued completes harmlessly.
- No combinational path from mem_rdata_i to any gnt output.

Decomposition:
- Package zeroriscy_dmem_pkg:
  - typedef arb_state_e {ARB, LOCK}
  - typedef mem_req_t struct {we, be, addr, wdata}
  - localparam M0/M1 owner encodings
- Sub-module zeroriscy_dmem_rr: 2-input round-robin picker with pointer register and mask input for LOCK. Everything else lives in the top module.

Test Plan:
- m0 read at 0x00000100 alone, SRAM word 0x40 = 0xDEADBEEF -> m0_gnt same cycle, mem_addr_o=0x040; m0_rvalid next cycle with rdata 0xDEADBEEF; m1 outputs silent.
- m0 and m1 requesting every cycle for 8 cycles -> grants alternate m0,m1,m0,...; 4 each; rvalid follows each grant by 1 cycle on the correct master.
- m1 writes with lock=1 to addresses 0..0x3C, byte-enables 0xF -> 16 consecutive m1 grants; m0 held off despite req=1; m0 granted the cycle after lock drops.
- Lock held for LOCK_MAX+5 m1 requests with m0 requesting -> forced release after 256 grants; next grant goes to m0.
- Reset asserted the cycle after an m0 grant -> no m0_rvalid; all outputs 0; first post-reset contention grant goes to m0.
- m0 write 0x00000001 to 0x1000 (be=0x1), then m1 read 0x1000 -> m1_rdata LSB = 0x01 and m0 write rvalid observed.
